// File: rtl/la_ioringseq.sv
// IO-ring power sequencer: waits for supply-good, then ramps ring control lines up/down one at a time.
// Optional LA_IORINGSEQ_PGSYNC_EN adds a 2-flop synchronizer on pgood.
module la_ioringseq #(
    parameter int RINGW = 8,
    parameter int DLYW  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic             pgood,
    input  logic [DLYW-1:0]  dly,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             fault
);

    localparam int IW = $clog2(RINGW + 1);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_WAIT_PG = 3'd1;
    localparam logic [2:0] S_RAMP    = 3'd2;
    localparam logic [2:0] S_ON      = 3'd3;
    localparam logic [2:0] S_DOWN    = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    // Timeout fires on the edge where the counter would reach all-ones.
    localparam logic [DLYW-1:0] CNT_LAST = {{(DLYW-1){1'b1}}, 1'b0};
    localparam logic [IW-1:0]   IDX_LAST = IW'(RINGW - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    logic [2:0]      state;
    logic [DLYW-1:0] cnt;
    logic [DLYW-1:0] dly_q;
    logic [IW-1:0]   idx;
    logic            pgood_s;

`ifdef LA_IORINGSEQ_PGSYNC_EN
    logic pg_meta;
    logic pg_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pg_meta <= 1'b0;
            pg_sync <= 1'b0;
        end else begin
            pg_meta <= pgood;
            pg_sync <= pg_meta;
        end
    end

    assign pgood_s = pg_sync;
`else
    assign pgood_s = pgood;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= S_OFF;
            cnt    <= '0;
            dly_q  <= '0;
            idx    <= '0;
            ioring <= '0;
            ready  <= 1'b0;
            fault  <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    if (en) begin
                        state <= S_WAIT_PG;
                        cnt   <= '0;
                    end
                end
                S_WAIT_PG: begin
                    if (!en) begin
                        state <= S_OFF;
                    end else if (pgood_s) begin
                        state <= S_RAMP;
                        cnt   <= '0;
                        idx   <= '0;
                        dly_q <= dly;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RAMP, S_ON, S_DOWN: begin
                    // Supply loss overrides everything: drop all lines in one edge.
                    if (!pgood_s) begin
                        state  <= S_FAULT;
                        ioring <= '0;
                        ready  <= 1'b0;
                        fault  <= 1'b1;
                        idx    <= '0;
                    end else if (state == S_RAMP) begin
                        if (!en) begin
                            state <= (idx == '0) ? S_OFF : S_DOWN;
                            cnt   <= '0;
                            dly_q <= dly;
                        end else if (cnt == dly_q) begin
                            ioring <= {ioring[RINGW-2:0], 1'b1};
                            cnt    <= '0;
                            idx    <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= S_ON;
                                ready <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (state == S_ON) begin
                        if (!en) begin
                            state <= S_DOWN;
                            ready <= 1'b0;
                            cnt   <= '0;
                            dly_q <= dly;
                        end
                    end else begin
                        // Lines are contiguous from bit 0, so a right shift clears the highest one.
                        if (cnt == dly_q) begin
                            ioring <= {1'b0, ioring[RINGW-1:1]};
                            cnt    <= '0;
                            idx    <= idx - 1'b1;
                            if (idx == IDX_ONE) state <= S_OFF;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    ioring <= '0;
                    fault  <= 1'b1;
                    if (!en) begin
                        state <= S_OFF;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    ioring <= '0;
                    ready  <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_ioringseq.sv
// Directed bench for la_ioringseq with RINGW=4, DLYW=4, dly=2.
// Honors LA_IORINGSEQ_PGSYNC_EN for the pgood-loss latency.
module tb_la_ioringseq;

`ifdef LA_IORINGSEQ_PGSYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk;
    logic       nreset;
    logic       en;
    logic       pgood;
    logic [3:0] dly;
    logic [3:0] ioring;
    logic       ready;
    logic       fault;

    int total_cnt = 0;
    int pass_cnt  = 0;

    la_ioringseq #(.RINGW(4), .DLYW(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .pgood  (pgood),
        .dly    (dly),
        .ioring (ioring),
        .ready  (ready),
        .fault  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] fill(input int n);
        logic [4:0] one;
        one = 5'd1;
        return 4'((one << n) - 5'd1);
    endfunction

    // From OFF with pgood_s high: bits at edges 5,8,11,14 after en rises.
    task automatic ramp_up(input string tag);
        int n;
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            n = (k < 5) ? 0 : (k - 2) / 3;
            check({tag, "_ring"}, 32'(ioring), 32'(fill(n)));
            check({tag, "_ready"}, 32'(ready), 32'(k == 14));
        end
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    // From ON: ready drops at edge 1, bits clear at edges 4,7,10,13; en pulse must be ignored.
    task automatic ramp_down(input string tag);
        en = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step(1);
            check({tag, "_ring"}, 32'(ioring), 32'(fill(4 - (k - 1) / 3)));
            check({tag, "_ready"}, 32'(ready), 32'd0);
            if (k == 5) en = 1'b1;
            if (k == 11) en = 1'b0;
        end
        step(3);
        check({tag, "_off"}, 32'(ioring), 32'd0);
    endtask

    initial begin
        int lat;
        nreset = 1'b0;
        en     = 1'b0;
        pgood  = 1'b1;
        dly    = 4'd2;
        #1;
        check("rst_ring", 32'(ioring), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        step(2);
        nreset = 1'b1;
        step(4);
        check("idle_ring", 32'(ioring), 32'd0);

        ramp_up("ramp1");
        ramp_down("down1");

        // Abort after 0011: 0001 three edges later, 0000 three more.
        en = 1'b1;
        step(8);
        check("abort_pre", 32'(ioring), 32'h3);
        en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("abort_ring", 32'(ioring), 32'(fill(2 - (k - 1) / 3)));
        end
        // Re-ramp timing proves the abort landed in OFF.
        ramp_up("ramp2");

        // Supply loss in ON.
        pgood = 1'b0;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (lat == 0 && ioring == 4'd0 && fault) lat = k;
        end
        check("loss_latency", 32'(lat), 32'(SYNC + 1));
        check("loss_ready", 32'(ready), 32'd0);
        en = 1'b0;
        step(1);
        check("loss_clear", 32'(fault), 32'd0);
        check("loss_ring", 32'(ioring), 32'd0);

        // Abort before the first bit: RAMP at edge 2, OFF at edge 3.
        pgood = 1'b1;
        step(SYNC + 2);
        en = 1'b1;
        step(2);
        en = 1'b0;
        step(1);
        check("early_ring", 32'(ioring), 32'd0);
        step(2);
        check("early_ring2", 32'(ioring), 32'd0);
        ramp_up("ramp3");
        ramp_down("down2");

        // pgood timeout: 15 cycles in WAIT_PG, fault visible at edge 16.
        pgood = 1'b0;
        step(SYNC + 2);
        en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            check("tmo_fault", 32'(fault), 32'(k >= 16));
            check("tmo_ring", 32'(ioring), 32'd0);
        end
        en = 1'b0;
        step(1);
        check("tmo_clear", 32'(fault), 32'd0);

        // Async reset mid-ramp.
        pgood = 1'b1;
        step(SYNC + 2);
        en = 1'b1;
        step(8);
        check("mid_pre", 32'(ioring), 32'h3);
        nreset = 1'b0;
        #1;
        check("mid_rst_ring", 32'(ioring), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        en = 1'b0;
        step(2);
        nreset = 1'b1;
        step(SYNC + 2);
        ramp_up("ramp4");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/la_ioringseq.md
# la_ioringseq

IO-ring power sequencer: the active controller on the far end of the generic `ioring` bus that the IO supply cells (vdd/vdda/vddio) passively carry. On request it waits for the analog supply-good indication, then asserts the `RINGW` ring control lines one at a time at programmable intervals. It also de-sequences them in reverse order and forces a safe all-off state on supply loss. One instance sits in the chip top next to the padring, one per ring segment.

## Interface
- `RINGW`, 8, number of ring control lines sequenced (≥2)
- `DLYW`, 8, width of step-delay field and of the internal interval/timeout counter
- `clk`  input  1  sequencer clock
- `nreset`  input  1  asynchronous active-low reset
- `en`  input  1  power request level; 1 = sequence up / stay on, 0 = sequence down
- `pgood`  input  1  supply-good from analog monitor, asynchronous to `clk`
- `dly`  input  DLYW  step interval; each ring line changes every `dly+1` cycles
- `ioring`  output  RINGW  ring control lines; bit 0 enabled first and disabled last
- `ready`  output  1  all ring lines on and stable (state ON)
- `fault`  output  1  supply loss or pgood timeout; sticky until `en`=0

## Operation
- Reset: state OFF, `ioring`=0, `ready`=0, `fault`=0, counter=0, index=0, latched delay=0.
- States: OFF, WAIT_PG, RAMP, ON, DOWN, FAULT.
- OFF: `en`=1 → WAIT_PG; counter cleared.
- WAIT_PG: `en`=0 → OFF. `pgood_s`=1 → RAMP; counter=0, index=0, `dly` latched. Counter reaches 2^DLYW-1 without `pgood_s` → FAULT.
- RAMP: counter increments each cycle. When counter == latched delay: set `ioring[index]`, counter=0, index+1. Setting bit RINGW-1 → ON.
- ON: `ready`=1. `en`=0 → DOWN; counter=0, `dly` re-latched.
- DOWN: every latched-delay+1 cycles clear the highest set bit. Clearing bit 0 → OFF. `en` re-asserted during DOWN is ignored until OFF is reached.
- `en`=0 during RAMP → DOWN immediately; `dly` re-latched; reverse clearing starts from the highest bit already set. If no bit is set yet → OFF directly.
- `pgood_s`=0 in RAMP, ON or DOWN → FAULT. On entry, all `ioring` bits are cleared in the same edge (no sequencing) and `fault`=1.
- FAULT: hold `ioring`=0 and `fault`=1 until `en`=0, then go to OFF (clears `fault`).
- `dly` changes are ignored except at latch points.
- Priority when events coincide: pgood loss > `en` drop > step completion.

## Timing
- All outputs are registered. Every state change and `ioring` update occurs on a `clk` rising edge.
- WAIT_PG is entered 1 cycle after `en` is sampled high in OFF.
- RAMP is entered 1 cycle after WAIT_PG samples `pgood_s`=1.
- First bit rises `dly+1` cycles after RAMP entry. Each later bit follows `dly+1` cycles after the previous one. `dly`=0 gives one bit per cycle.
- `ready` rises on the same edge as `ioring[RINGW-1]`. `ready` falls on the edge that leaves ON.
- Total ramp from RAMP entry to `ready`: RINGW×(dly+1) cycles.
- On supply loss, `ioring` reaches 0 on the edge after `pgood_s` is sampled low.
- Asserting `nreset` at any time clears all outputs asynchronously, including mid-ramp. Deassertion restarts from OFF.

## Configuration
- `LA_IORINGSEQ_PGSYNC_EN` defined: `pgood` passes through a 2-flop synchronizer (reset to 0) to form `pgood_s`. This adds 2 cycles to every pgood-related response.
- Not defined: `pgood_s` = `pgood` directly. Use this only when `pgood` is already synchronous to `clk`.
- The test plan latencies below assume the macro is defined.

## Test plan
- Ramp, RINGW=4, DLYW=4, dly=2, `pgood`=1 held from reset:
  - `en`↑ → `ioring` 0001 at 5 cycles after `en` sampled.
  - Then 0011 / 0111 / 1111 every 3 cycles.
  - `ready`=1 together with 1111.
- Down, from ON:
  - `en`=0 → `ready`=0 next edge.
  - `ioring` 0111, 0011, 0001, 0000 at 3-cycle intervals, then OFF.
  - `en`↑ during DOWN has no effect.
- Supply loss in ON: drop `pgood` → `ioring`=0000 and `fault`=1 within 3 cycles. Then `en`=0 → `fault`=0 next cycle.
- Abort mid-ramp:
  - `en`=0 right after 0011 → 0001 after 3 cycles → 0000 after 3 more → OFF.
  - Repeat with `en`=0 before the first bit → OFF next edge, `ioring` stays 0000.
- Timeout, DLYW=4: `en`=1, `pgood`=0 → `fault`=1 after 15 cycles in WAIT_PG, `ioring`=0000 throughout.
- Reset mid-ramp: `nreset`=0 while `ioring`=0011 → all outputs 0 immediately. A re-ramp after release matches the first scenario.
